// File: rtl/stopwatch_pkg.sv
// ---------------------------------------------------------------------------
// stopwatch_pkg
// Shared definitions for the stopwatch display path: active-low seven-segment
// glyph codes ({g,f,e,d,c,b,a}, 0 = lit), the invalid-BCD marker, digit index
// constants, the scan decoder FSM state type and small anode helper functions.
// ---------------------------------------------------------------------------
package stopwatch_pkg;

  // Active-low glyphs for 0-9.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  // Tail-less renderings some drivers use for 6 and 9.
  localparam logic [6:0] SEG_6_ALT = 7'h03;
  localparam logic [6:0] SEG_9_ALT = 7'h18;
  // All segments dark.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] BCD_INVALID = 4'hF;

  localparam logic [1:0] DIG_SEC_ONES = 2'd0;
  localparam logic [1:0] DIG_SEC_TENS = 2'd1;
  localparam logic [1:0] DIG_MIN_ONES = 2'd2;
  localparam logic [1:0] DIG_MIN_TENS = 2'd3;

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } scan_state_t;

  // Number of active (low) anodes.
  function automatic logic [2:0] count_low(input logic [3:0] an);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (!an[i]) n = n + 3'd1;
    end
    return n;
  endfunction

  function automatic logic is_onehot_low(input logic [3:0] an);
    return count_low(an) == 3'd1;
  endfunction

  // Digit index of a one-hot-low anode vector; only meaningful when one-hot.
  function automatic logic [1:0] anode_index(input logic [3:0] an);
    logic [1:0] idx;
    idx = DIG_SEC_ONES;
    if (!an[1]) idx = DIG_SEC_TENS;
    if (!an[2]) idx = DIG_MIN_ONES;
    if (!an[3]) idx = DIG_MIN_TENS;
    return idx;
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// ---------------------------------------------------------------------------
// seg7_to_bcd
// Combinational inverse of the seven-segment encoder. Maps an active-low glyph
// to its BCD value; anything outside the 0-9 table (including the 6/9 tail
// variants' neighbours and the all-dark glyph) reports valid=0, bcd=4'hF.
// Ports:
//   seg   in  7  glyph {g,f,e,d,c,b,a}, active-low
//   valid out 1  glyph recognised
//   bcd   out 4  decoded digit, BCD_INVALID when not recognised
// ---------------------------------------------------------------------------
module seg7_to_bcd
  import stopwatch_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic [3:0] bcd
);

  always_comb begin
    valid = 1'b1;
    bcd   = BCD_INVALID;
    case (seg)
      SEG_0:            bcd = 4'd0;
      SEG_1:            bcd = 4'd1;
      SEG_2:            bcd = 4'd2;
      SEG_3:            bcd = 4'd3;
      SEG_4:            bcd = 4'd4;
      SEG_5:            bcd = 4'd5;
      SEG_6, SEG_6_ALT: bcd = 4'd6;
      SEG_7:            bcd = 4'd7;
      SEG_8:            bcd = 4'd8;
      SEG_9, SEG_9_ALT: bcd = 4'd9;
      default:          valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_decoder
// Watches a multiplexed 4-digit seven-segment display (seg/an pins), waits for
// each scanned digit to settle, decodes it back to BCD and publishes a whole
// frame atomically once all four digits have been captured.
// Ports:
//   clk          in   1  system clock
//   reset        in   1  asynchronous active-low reset
//   seg          in   7  segments {g,f,e,d,c,b,a}, active-low, asynchronous
//   an           in   4  anodes, active-low one-hot, an[0] = sec_ones
//   digit0..3    out  4  sec_ones, sec_tens, min_ones, min_tens (4'hF = bad glyph)
//   frame_valid  out  1  pulse when digit0..3 update
//   seg_err      out  1  pulse: captured glyph not recognised
//   anode_err    out  1  pulse: first cycle of a multi-hot anode episode
//   stale        out  1  level: no capture for STALE_CYCLES, cleared by next frame
// ---------------------------------------------------------------------------
module seven_seg_scan_decoder
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int STALE_CYCLES  = 1 << 20,
  parameter int STALE_W       = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg,
  input  logic [3:0] an,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       frame_valid,
  output logic       seg_err,
  output logic       anode_err,
  output logic       stale
);

  localparam int CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  // The WAIT->SETTLE transition already counts as the first matching sample,
  // so SETTLE only needs SETTLE_CYCLES-1 further matches.
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [STALE_W-1:0] STALE_MAX   = STALE_W'(STALE_CYCLES);

  // -------------------------------------------------------------------------
  // Input synchronizer. Resets to "display dark" so the FSM starts idle.
  // -------------------------------------------------------------------------
  logic [6:0] seg_sync_reg [SYNC_STAGES];
  logic [3:0] an_sync_reg  [SYNC_STAGES];
  logic [6:0] seg_s;
  logic [3:0] an_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        seg_sync_reg[i] <= SEG_BLANK;
        an_sync_reg[i]  <= 4'hF;
      end
    end else begin
      seg_sync_reg[0] <= seg;
      an_sync_reg[0]  <= an;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        seg_sync_reg[i] <= seg_sync_reg[i-1];
        an_sync_reg[i]  <= an_sync_reg[i-1];
      end
    end
  end

  assign seg_s = seg_sync_reg[SYNC_STAGES-1];
  assign an_s  = an_sync_reg[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // Scan FSM, shadow digits, capture mask and frame publication.
  // -------------------------------------------------------------------------
  scan_state_t      state_reg;
  logic [CNT_W-1:0] settle_cnt_reg;
  logic [3:0]       snap_an_reg;
  logic [6:0]       snap_seg_reg;
  logic [3:0]       shadow_reg [4];
  logic [3:0]       digit_reg  [4];
  logic [3:0]       mask_reg;
  logic [3:0]       mask_next;
  logic             frame_valid_reg;
  logic             seg_err_reg;

  logic             glyph_valid;
  logic [3:0]       glyph_bcd;
  logic             capture_fire;
  logic             frame_fire;
  logic             sample_changed;
  logic [1:0]       cap_idx;

  // The snapshot is what has been stable through SETTLE, so it is the glyph
  // that gets decoded in CAPTURE.
  seg7_to_bcd u_seg7_to_bcd (
    .seg   (snap_seg_reg),
    .valid (glyph_valid),
    .bcd   (glyph_bcd)
  );

  assign capture_fire   = (state_reg == ST_CAPTURE);
  assign frame_fire     = (mask_reg == 4'hF);
  assign cap_idx        = anode_index(snap_an_reg);
  assign sample_changed = (an_s != snap_an_reg) || (seg_s != snap_seg_reg);

  // Publishing a frame empties the mask, but a capture in the same cycle must
  // still land in the fresh mask.
  always_comb begin
    mask_next = frame_fire ? 4'b0000 : mask_reg;
    if (capture_fire) begin
      mask_next = mask_next | (4'b0001 << cap_idx);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= ST_WAIT;
      settle_cnt_reg  <= '0;
      snap_an_reg     <= 4'hF;
      snap_seg_reg    <= SEG_BLANK;
      mask_reg        <= 4'b0000;
      frame_valid_reg <= 1'b0;
      seg_err_reg     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        shadow_reg[i] <= 4'd0;
        digit_reg[i]  <= 4'd0;
      end
    end else begin
      frame_valid_reg <= frame_fire;
      seg_err_reg     <= 1'b0;
      mask_reg        <= mask_next;

      if (frame_fire) begin
        for (int i = 0; i < 4; i++) begin
          digit_reg[i] <= shadow_reg[i];
        end
      end

      case (state_reg)
        ST_WAIT: begin
          // Blank and multi-hot patterns are simply ignored here.
          if (is_onehot_low(an_s)) begin
            state_reg      <= ST_SETTLE;
            snap_an_reg    <= an_s;
            snap_seg_reg   <= seg_s;
            settle_cnt_reg <= CNT_W'(1);
          end
        end
        ST_SETTLE: begin
          if (sample_changed) begin
            snap_an_reg    <= an_s;
            snap_seg_reg   <= seg_s;
            settle_cnt_reg <= CNT_W'(1);
            if (!is_onehot_low(an_s)) begin
              state_reg <= ST_WAIT;
            end
          end else if (settle_cnt_reg >= SETTLE_LAST) begin
            state_reg <= ST_CAPTURE;
          end else begin
            settle_cnt_reg <= settle_cnt_reg + 1'b1;
          end
        end
        ST_CAPTURE: begin
          shadow_reg[cap_idx] <= glyph_valid ? glyph_bcd : BCD_INVALID;
          seg_err_reg         <= !glyph_valid;
          state_reg           <= ST_HOLD;
        end
        ST_HOLD: begin
          // Only a new anode starts the next capture; segment changes while the
          // same digit is lit are not re-sampled.
          if (an_s != snap_an_reg) begin
            state_reg <= ST_WAIT;
          end
        end
        default: state_reg <= ST_WAIT;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Anode error edge detect and stale watchdog.
  // -------------------------------------------------------------------------
  logic               multi_hot;
  logic               multi_prev_reg;
  logic               anode_err_reg;
  logic [STALE_W-1:0] stale_cnt_reg;
  logic               stale_reg;

  assign multi_hot = (count_low(an_s) > 3'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      multi_prev_reg <= 1'b0;
      anode_err_reg  <= 1'b0;
      stale_cnt_reg  <= '0;
      stale_reg      <= 1'b0;
    end else begin
      multi_prev_reg <= multi_hot;
      anode_err_reg  <= multi_hot && !multi_prev_reg;

      if (capture_fire) begin
        stale_cnt_reg <= '0;
      end else if (stale_cnt_reg != STALE_MAX) begin
        stale_cnt_reg <= stale_cnt_reg + 1'b1;
      end

      // stale rises on the edge where the counter reaches saturation and only
      // a completed frame brings it back down.
      if (frame_fire) begin
        stale_reg <= 1'b0;
      end else if (!capture_fire && (stale_cnt_reg >= STALE_MAX - 1'b1)) begin
        stale_reg <= 1'b1;
      end
    end
  end

  assign digit0      = digit_reg[0];
  assign digit1      = digit_reg[1];
  assign digit2      = digit_reg[2];
  assign digit3      = digit_reg[3];
  assign frame_valid = frame_valid_reg;
  assign seg_err     = seg_err_reg;
  assign anode_err   = anode_err_reg;
  assign stale       = stale_reg;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scan_decoder
// Drives scanned seg/an patterns, keeps a frame-level reference model (glyph
// table lookup, capture mask, shadow digits) that pushes expected frames into
// a queue, and a monitor that pops and compares on every frame_valid.
// ---------------------------------------------------------------------------
module tb_seven_seg_scan_decoder;

  localparam int STALE_T = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] seg = 7'h7F;
  logic [3:0] an = 4'hF;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic       frame_valid, seg_err, anode_err, stale;

  always #5 clk = ~clk;

  seven_seg_scan_decoder #(
    .SYNC_STAGES   (2),
    .SETTLE_CYCLES (4),
    .STALE_CYCLES  (STALE_T),
    .STALE_W       (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .seg         (seg),
    .an          (an),
    .digit0      (digit0),
    .digit1      (digit1),
    .digit2      (digit2),
    .digit3      (digit3),
    .frame_valid (frame_valid),
    .seg_err     (seg_err),
    .anode_err   (anode_err),
    .stale       (stale)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [15:0] exp_q [$];
  logic [3:0]  m_shadow [4];
  logic [3:0]  m_mask;
  logic [3:0]  last_an;
  int exp_seg_err = 0, seen_seg_err = 0;
  int exp_anode_err = 0, seen_anode_err = 0;
  int frames_seen = 0;
  logic [6:0] glyph_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0] ref_decode(input logic [6:0] g);
    for (int d = 0; d < 10; d++) begin
      if (glyph_tab[d] == g) return 4'(d);
    end
    if (g == 7'h03) return 4'd6;
    if (g == 7'h18) return 4'd9;
    return 4'hF;
  endfunction

  task automatic model_reset();
    m_mask = 4'b0000;
    for (int i = 0; i < 4; i++) m_shadow[i] = 4'd0;
    exp_q.delete();
    last_an = 4'hF;
  endtask

  // Light one digit for ncyc cycles (ncyc >= 8 gives the decoder time to settle).
  task automatic show(input int idx, input logic [6:0] g, input int ncyc);
    logic [3:0] a;
    logic [3:0] d;
    a = ~(4'b0001 << idx);
    @(posedge clk); #1;
    an  = a;
    seg = g;
    if (a != last_an) begin
      d = ref_decode(g);
      if (d == 4'hF) exp_seg_err++;
      m_shadow[idx] = d;
      m_mask[idx]   = 1'b1;
      if (m_mask == 4'hF) begin
        exp_q.push_back({m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]});
        m_mask = 4'b0000;
      end
    end
    last_an = a;
    repeat (ncyc - 1) @(posedge clk);
  endtask

  task automatic blank(input int ncyc);
    @(posedge clk); #1;
    an  = 4'hF;
    seg = 7'h7F;
    last_an = 4'hF;
    repeat (ncyc - 1) @(posedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " digit0"}, digit0, 0);
    check({tag, " digit1"}, digit1, 0);
    check({tag, " digit2"}, digit2, 0);
    check({tag, " digit3"}, digit3, 0);
    check({tag, " frame_valid"}, frame_valid, 0);
    check({tag, " seg_err"}, seg_err, 0);
    check({tag, " anode_err"}, anode_err, 0);
    check({tag, " stale"}, stale, 0);
  endtask

  // Monitor: one line per published frame, compared against the scoreboard.
  always @(negedge clk) begin
    logic [15:0] want;
    if (reset === 1'b1) begin
      if (seg_err)   seen_seg_err++;
      if (anode_err) seen_anode_err++;
      if (frame_valid) begin
        frames_seen++;
        $display("frame %0d: digit3..0 = %h %h %h %h", frames_seen,
                 digit3, digit2, digit1, digit0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame: got %h%h%h%h, expected no frame",
                   digit3, digit2, digit1, digit0);
        end else begin
          want = exp_q.pop_front();
          check("frame digit0", digit0, want[3:0]);
          check("frame digit1", digit1, want[7:4]);
          check("frame digit2", digit2, want[11:8]);
          check("frame digit3", digit3, want[15:12]);
        end
        check("stale clear with frame", stale, 0);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fs;
    int prev;
    int idx;
    int r;
    logic [6:0] g;

    model_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b1;

    // Basic scan 5,1,2,0.
    show(0, 7'h12, 8);
    show(1, 7'h79, 8);
    show(2, 7'h24, 8);
    show(3, 7'h40, 8);
    blank(6);
    @(negedge clk);
    check("scan frames pending", exp_q.size(), 0);
    check("scan digit0", digit0, 5);
    check("scan digit1", digit1, 1);
    check("scan digit2", digit2, 2);
    check("scan digit3", digit3, 0);

    // Reset in the middle of a frame (two digits captured).
    show(0, 7'h10, 10);
    show(1, 7'h02, 10);
    blank(3);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check_all_zero("midframe reset");
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    fs = frames_seen;
    show(2, 7'h30, 10);
    show(3, 7'h19, 10);
    blank(10);
    check("no frame after two fresh captures", frames_seen, fs);
    show(0, 7'h78, 10);
    show(1, 7'h00, 10);
    blank(5);
    check("post-reset frame count", frames_seen, fs + 1);
    check("post-reset frames pending", exp_q.size(), 0);

    // Segment chatter faster than the settle window: no capture, stale rises.
    fs = frames_seen;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      an  = 4'hE;
      seg = (k % 2 == 1) ? 7'h79 : 7'h78;
      repeat (2) @(posedge clk);
    end
    blank(4);
    @(negedge clk);
    check("chatter stale", stale, 1);
    check("chatter no frame", frames_seen, fs);

    // Multi-hot anodes in the middle of a frame, then a bad glyph on digit2.
    show(0, 7'h19, 10);
    show(1, 7'h12, 10);
    r = seen_anode_err;
    @(posedge clk); #1;
    an  = 4'b1100;
    seg = 7'h40;
    last_an = 4'b1100;
    repeat (9) @(posedge clk);
    blank(10);
    exp_anode_err++;
    check("multi-hot single anode_err", seen_anode_err - r, 1);
    r = seen_anode_err;
    blank(10);
    check("blank no anode_err", seen_anode_err - r, 0);
    show(2, 7'h7F, 10);
    show(3, 7'h03, 10);
    blank(5);
    @(negedge clk);
    check("bad glyph digit2", digit2, 15);
    check("bad glyph seg_err count", seen_seg_err, exp_seg_err);
    check("stale after frame", stale, 0);

    // Randomized scanning with valid, tail-variant and arbitrary glyphs.
    prev = -1;
    for (int n = 0; n < 120; n++) begin
      idx = $urandom_range(0, 3);
      while (idx == prev) idx = $urandom_range(0, 3);
      prev = idx;
      r = $urandom_range(0, 15);
      if (r < 10)       g = glyph_tab[r];
      else if (r == 10) g = 7'h03;
      else if (r == 11) g = 7'h18;
      else              g = 7'($urandom_range(0, 127));
      show(idx, g, $urandom_range(10, 14));
      if ($urandom_range(0, 9) == 0) blank($urandom_range(2, 5));
    end
    blank(10);
    check("random frames pending", exp_q.size(), 0);
    check("random seg_err count", seen_seg_err, exp_seg_err);

    // Stale timing: idle well under, then well over STALE_T cycles.
    show(0, 7'h40, 10);
    show(1, 7'h79, 10);
    show(2, 7'h24, 10);
    show(3, 7'h30, 10);
    blank(40);
    @(negedge clk);
    check("stale below limit", stale, 0);
    blank(40);
    @(negedge clk);
    check("stale above limit", stale, 1);
    show(0, 7'h12, 10);
    show(1, 7'h02, 10);
    show(2, 7'h78, 10);
    show(3, 7'h00, 10);
    blank(5);
    @(negedge clk);
    check("stale cleared by frame", stale, 0);
    check("final frames pending", exp_q.size(), 0);
    check("final anode_err count", seen_anode_err, exp_anode_err);
    check("final seg_err count", seen_seg_err, exp_seg_err);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
